// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : seg_pkg
// Description : Shared definitions for the seven-segment scan driver and its
//               receive-side decoder: active-low hex segment codes, the blank
//               pattern, the default digit count and the scan FSM state type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // Active-low segment codes, seg[0]=a .. seg[6]=g, seg[7]=dp (dp off).
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  // All seven segments dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int DIGITS_DEF = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } seg_state_t;

endpackage
`default_nettype wire

// File: rtl/seg_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_pattern_decode
// Description : Combinational lookup of a 7-bit active-low segment pattern
//               (dp excluded) into {legal, blank, value}.
// Ports       : pat_i   [6:0] active-low segments a..g
//               legal_o       pattern is one of the 16 hex glyphs
//               blank_o       pattern is all segments off
//               value_o [3:0] hex value when legal_o, else 0
// Revision    : 1.0 - initial release
// ============================================================================
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic       legal_o,
  output logic       blank_o,
  output logic [3:0] value_o
);

  always_comb begin
    legal_o = 1'b1;
    blank_o = 1'b0;
    value_o = 4'h0;
    case (pat_i)
      SEG_0[6:0]: value_o = 4'h0;
      SEG_1[6:0]: value_o = 4'h1;
      SEG_2[6:0]: value_o = 4'h2;
      SEG_3[6:0]: value_o = 4'h3;
      SEG_4[6:0]: value_o = 4'h4;
      SEG_5[6:0]: value_o = 4'h5;
      SEG_6[6:0]: value_o = 4'h6;
      SEG_7[6:0]: value_o = 4'h7;
      SEG_8[6:0]: value_o = 4'h8;
      SEG_9[6:0]: value_o = 4'h9;
      SEG_A[6:0]: value_o = 4'hA;
      SEG_B[6:0]: value_o = 4'hB;
      SEG_C[6:0]: value_o = 4'hC;
      SEG_D[6:0]: value_o = 4'hD;
      SEG_E[6:0]: value_o = 4'hE;
      SEG_F[6:0]: value_o = 4'hF;
      SEG_BLANK: begin
        legal_o = 1'b0;
        blank_o = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Watches a multiplexed active-low sel/seg display bus, waits
//               for each scan slot to be stable for STABLE_CYCLES samples and
//               decodes the glyph back into a per-digit hex register.
// Ports       : clk, rstn (async, active-low)
//               sel  [DIGITS-1:0]   digit select, one-hot-low
//               seg  [7:0]          segments, active-low, seg[7]=dp
//               digits [4*DIGITS-1:0], digit_vld, dp  captured state
//               frame_done, err_sel, err_seg        one-cycle pulses
//               err_cnt [7:0]       only with SEG_DEC_ERR_CNT_EN defined
// Options     : `define SEG_DEC_ERR_CNT_EN adds a saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int DIGITS        = DIGITS_DEF,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DIGITS-1:0]     sel,
  input  logic [7:0]            seg,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_vld,
  output logic [DIGITS-1:0]     dp,
  output logic                  frame_done,
  output logic                  err_sel,
  output logic                  err_seg
`ifdef SEG_DEC_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam logic [3:0] c_stable = 4'(STABLE_CYCLES);

  logic [DIGITS-1:0]   s_sel_q;
  logic [7:0]          s_seg_q;
  seg_state_t          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   vld_q, vld_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic                frame_q, frame_d;
  logic                esel_q, esel_d;
  logic                eseg_q, eseg_d;

  logic                w_chg;
  logic                w_sel_idle;
  logic [3:0]          w_cnt_inc;
  logic [DIGITS-1:0]   w_low;
  logic                w_one_low;
  logic                w_capture;
  logic [DIGITS-1:0]   w_seen;
  logic                w_legal;
  logic                w_blank;
  logic [3:0]          w_value;

  seg_pattern_decode u_decode (
    .pat_i   (s_seg_q[6:0]),
    .legal_o (w_legal),
    .blank_o (w_blank),
    .value_o (w_value)
  );

  // The incoming sample is compared against the last registered one; the
  // register stage itself is the "previous sample".
  assign w_chg      = (sel != s_sel_q) || (seg != s_seg_q);
  assign w_sel_idle = &sel;
  assign w_cnt_inc  = cnt_q + 4'd1;
  assign w_low      = ~s_sel_q;
  // Exactly one select low: non-zero and a power of two.
  assign w_one_low  = (w_low != '0) && ((w_low & (w_low - DIGITS'(1))) == '0);

  // Scan-slot FSM. Capture fires on the edge where the count of equal
  // samples reaches STABLE_CYCLES, so outputs appear on that same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_chg && !w_sel_idle) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (w_chg) begin
          state_d = w_sel_idle ? IDLE : SETTLE;
          cnt_d   = '0;
        end else if (w_cnt_inc == c_stable) begin
          state_d   = CAPTURE;
          cnt_d     = w_cnt_inc;
          w_capture = 1'b1;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      default: begin  // CAPTURE lasts one cycle, then HOLD
        if (w_chg) begin
          state_d = w_sel_idle ? IDLE : SETTLE;
          cnt_d   = '0;
        end else begin
          state_d = HOLD;
        end
      end
    endcase
  end

  always_comb begin
    seen_d   = seen_q;
    digits_d = digits_q;
    vld_d    = vld_q;
    dp_d     = dp_q;
    frame_d  = 1'b0;
    esel_d   = 1'b0;
    eseg_d   = 1'b0;
    w_seen   = seen_q | w_low;
    if (w_capture) begin
      if (w_one_low) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (w_low[i]) begin
            dp_d[i] = ~s_seg_q[7];
            if (w_legal) begin
              digits_d[4*i +: 4] = w_value;
              vld_d[i]           = 1'b1;
            end else begin
              vld_d[i] = 1'b0;
              eseg_d   = ~w_blank;
            end
          end
        end
        // Completing the mask pulses frame_done and restarts the frame.
        if (&w_seen) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end else begin
          seen_d = w_seen;
        end
      end else if (w_low != '0) begin
        esel_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_sel_q  <= '1;
      s_seg_q  <= '1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      seen_q   <= '0;
      digits_q <= '0;
      vld_q    <= '0;
      dp_q     <= '0;
      frame_q  <= 1'b0;
      esel_q   <= 1'b0;
      eseg_q   <= 1'b0;
    end else begin
      s_sel_q  <= sel;
      s_seg_q  <= seg;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      digits_q <= digits_d;
      vld_q    <= vld_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
      esel_q   <= esel_d;
      eseg_q   <= eseg_d;
    end
  end

  assign digits     = digits_q;
  assign digit_vld  = vld_q;
  assign dp         = dp_q;
  assign frame_done = frame_q;
  assign err_sel    = esel_q;
  assign err_seg    = eseg_q;

`ifdef SEG_DEC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts alongside the pulse itself; sticks at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((esel_d || eseg_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire
